stream_combine: RTL and testbench

Parametrised N-channel pixel stream combiner; successor to the two-camera `pixel_combine`. It buffers one or more lines per channel in on-chip FIFOs and releases whole lines only once every channel holds a complete line. Output is in one of three modes: lockstep (all lanes side by side), concat (channel lines back to back) or select (one channel, others discarded in step). It sits between the per-camera RGB565 readers (already retimed into `clk`) and the sync generator / DDR write path, and adds valid/ready back-pressure, a flush, and per-channel overflow flags.

---
 rtl/stream_combine_pkg.sv | 30 +++
 rtl/sc_fifo.sv | 78 +++++++
 rtl/stream_combine.sv | 200 ++++++++++++++++++++
 tb/tb_stream_combine.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_combine_pkg.sv
// Shared types and helpers for the N-channel line-synchronised pixel stream combiner.
package stream_combine_pkg;

    typedef enum logic [1:0] {
        MODE_LOCKSTEP = 2'd0,
        MODE_CONCAT   = 2'd1,
        MODE_SELECT   = 2'd2
    } mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_OUTPUT = 1'b1
    } state_e;

    // The reserved encoding 3 behaves as lockstep.
    function automatic mode_e mode_decode(input logic [1:0] mode_raw);
        mode_e m;
        case (mode_raw)
            2'd1:    m = MODE_CONCAT;
            2'd2:    m = MODE_SELECT;
            default: m = MODE_LOCKSTEP;
        endcase
        return m;
    endfunction

    function automatic int beats_per_line(input mode_e m, input int n_ch, input int line_w);
        return (m == MODE_CONCAT) ? (n_ch * line_w) : line_w;
    endfunction

endpackage

// File: rtl/sc_fifo.sv
// First-word-fall-through FIFO with registered level, flush and sticky overflow flag.
// Also exposes the entry behind the head so the consumer can register its next beat.
module sc_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 2048,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [WIDTH-1:0] o_head_nxt,
    output logic [LVL_W-1:0] o_level,
    output logic             o_overflow
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_overflow;
    logic             w_full;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign w_full     = (r_level == LVL_W'(DEPTH));
    assign w_pop_ok   = i_pop && (r_level != '0);
    assign w_push_ok  = i_push && (!w_full || w_pop_ok);

    assign o_head     = r_mem[r_rd_ptr];
    assign o_head_nxt = r_mem[r_rd_ptr + PTR_W'(1)];
    assign o_level    = r_level;
    assign o_overflow = r_overflow;

    // Storage array; entries above the level are never observed, so no reset.
    always_ff @(posedge clk) begin
        if (w_push_ok && !i_flush && !rst) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers and level; flush wins over a same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky overflow survives a flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (!i_flush && i_push && !w_push_ok) begin
            r_overflow <= 1'b1;
        end else begin
            r_overflow <= r_overflow;
        end
    end

endmodule

// File: rtl/stream_combine.sv
// N-channel line combiner: buffers lines per channel and releases a line once every
// channel holds a complete one, in lockstep, concat or select layout with valid/ready.
module stream_combine
    import stream_combine_pkg::*;
#(
    parameter  int N_CH       = 2,
    parameter  int PIX_W      = 16,
    parameter  int LINE_W     = 1280,
    parameter  int FIFO_DEPTH = 2048,
    localparam int SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*PIX_W-1:0] in_data,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_CH*PIX_W-1:0] out_data,
    output logic                  out_sol,
    output logic                  out_eol,
    output logic [N_CH-1:0]       overflow
);

    localparam int BEAT_W = (N_CH * LINE_W > 1) ? $clog2(N_CH * LINE_W) : 1;
    localparam int PIX_CW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PIX_CW-1:0] PIX_LAST = PIX_CW'(LINE_W - 1);

    logic [N_CH-1:0][PIX_W-1:0] w_head;
    logic [N_CH-1:0][PIX_W-1:0] w_head_nxt;
    logic [N_CH-1:0][PIX_W-1:0] w_src;
    logic [N_CH-1:0][PIX_W-1:0] w_lanes;
    logic [N_CH-1:0][LVL_W-1:0] w_level;
    logic [N_CH-1:0]            w_pop;
    logic                       w_all_ready;
    logic                       w_beat_done;
    logic                       w_last;
    logic                       w_load;
    logic [SEL_W-1:0]           w_sel_ok;
    logic [BEAT_W-1:0]          w_last_idx;
    logic [BEAT_W-1:0]          w_nxt_last;

    state_e                     r_state,  w_nxt_state;
    mode_e                      r_mode,   w_nxt_mode;
    logic [SEL_W-1:0]           r_sel,    w_nxt_sel;
    logic [BEAT_W-1:0]          r_beat,   w_nxt_beat;
    logic [SEL_W-1:0]           r_ch,     w_nxt_ch;
    logic [PIX_CW-1:0]          r_pix,    w_nxt_pix;
    logic                       r_out_valid;
    logic                       r_out_sol;
    logic                       r_out_eol;
    logic [N_CH-1:0][PIX_W-1:0] r_out_data;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        sc_fifo #(
            .WIDTH (PIX_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .i_flush    (flush),
            .i_push     (in_valid[g]),
            .i_wr_data  (in_data[g*PIX_W +: PIX_W]),
            .i_pop      (w_pop[g]),
            .o_head     (w_head[g]),
            .o_head_nxt (w_head_nxt[g]),
            .o_level    (w_level[g]),
            .o_overflow (overflow[g])
        );
    end

    // An out-of-range select (non power-of-two channel count) falls back to channel 0.
    if ((1 << SEL_W) > N_CH) begin : g_sel_clamp
        assign w_sel_ok = (sel < SEL_W'(N_CH)) ? sel : '0;
    end else begin : g_sel_direct
        assign w_sel_ok = sel;
    end

    assign w_beat_done = r_out_valid && out_ready;
    assign w_last_idx  = BEAT_W'(beats_per_line(r_mode, N_CH, LINE_W) - 1);
    assign w_last      = (r_beat == w_last_idx);
    assign w_nxt_last  = BEAT_W'(beats_per_line(w_nxt_mode, N_CH, LINE_W) - 1);

    // Line-ready detection and per-channel pop strobes.
    always_comb begin
        w_all_ready = 1'b1;
        w_pop       = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_level[i] < LVL_W'(LINE_W)) begin
                w_all_ready = 1'b0;
            end else begin
                w_all_ready = w_all_ready;
            end
            w_pop[i] = w_beat_done && ((r_mode != MODE_CONCAT) || (r_ch == SEL_W'(i)));
        end
    end

    // Next FSM state plus the FIFO entries that will form the next registered beat.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_mode  = r_mode;
        w_nxt_sel   = r_sel;
        w_nxt_beat  = r_beat;
        w_nxt_ch    = r_ch;
        w_nxt_pix   = r_pix;
        w_src       = w_head;
        w_load      = 1'b0;
        if (r_state == ST_IDLE) begin
            w_nxt_beat = '0;
            w_nxt_ch   = '0;
            w_nxt_pix  = '0;
            if (w_all_ready) begin
                w_nxt_state = ST_OUTPUT;
                w_nxt_mode  = mode_decode(mode);
                w_nxt_sel   = w_sel_ok;
                w_load      = 1'b1;
            end else begin
                w_nxt_state = ST_IDLE;
            end
        end else if (w_beat_done) begin
            if (w_last) begin
                w_nxt_state = ST_IDLE;
            end else begin
                w_nxt_beat = r_beat + BEAT_W'(1);
                w_load     = 1'b1;
                if (r_mode == MODE_CONCAT) begin
                    // Crossing into the next channel shows its untouched head.
                    if (r_pix == PIX_LAST) begin
                        w_nxt_ch  = r_ch + SEL_W'(1);
                        w_nxt_pix = '0;
                    end else begin
                        w_nxt_pix    = r_pix + PIX_CW'(1);
                        w_src[r_ch]  = w_head_nxt[r_ch];
                    end
                end else begin
                    w_nxt_pix = r_pix + PIX_CW'(1);
                    w_src     = w_head_nxt;
                end
            end
        end else begin
            w_nxt_state = r_state;
        end
    end

    // Lane packing for the beat about to be registered.
    always_comb begin
        w_lanes = '0;
        case (w_nxt_mode)
            MODE_CONCAT: w_lanes[0] = w_src[w_nxt_ch];
            MODE_SELECT: w_lanes[0] = w_src[w_nxt_sel];
            default:     w_lanes    = w_src;
        endcase
    end

    // FSM, counters and the registered output beat.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state     <= ST_IDLE;
            r_mode      <= MODE_LOCKSTEP;
            r_sel       <= '0;
            r_beat      <= '0;
            r_ch        <= '0;
            r_pix       <= '0;
            r_out_valid <= 1'b0;
            r_out_sol   <= 1'b0;
            r_out_eol   <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_mode      <= w_nxt_mode;
            r_sel       <= w_nxt_sel;
            r_beat      <= w_nxt_beat;
            r_ch        <= w_nxt_ch;
            r_pix       <= w_nxt_pix;
            r_out_valid <= (w_nxt_state == ST_OUTPUT);
            if (w_load) begin
                r_out_data <= w_lanes;
                r_out_sol  <= (w_nxt_beat == '0);
                r_out_eol  <= (w_nxt_beat == w_nxt_last);
            end else if (w_nxt_state == ST_IDLE) begin
                r_out_data <= '0;
                r_out_sol  <= 1'b0;
                r_out_eol  <= 1'b0;
            end else begin
                r_out_data <= r_out_data;
                r_out_sol  <= r_out_sol;
                r_out_eol  <= r_out_eol;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sol   = r_out_sol;
    assign out_eol   = r_out_eol;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_stream_combine.sv
// Directed bench for stream_combine with 2 channels, 16-bit pixels, 8-pixel lines, 16-deep FIFOs.
module tb_stream_combine;

    localparam int N_CH       = 2;
    localparam int PIX_W      = 16;
    localparam int LINE_W     = 8;
    localparam int FIFO_DEPTH = 16;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [1:0]  in_valid;
    logic [31:0] in_data;
    logic [1:0]  mode;
    logic [0:0]  sel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sol;
    logic        out_eol;
    logic [1:0]  overflow;

    int n_checks;
    int n_errors;

    stream_combine #(
        .N_CH       (N_CH),
        .PIX_W      (PIX_W),
        .LINE_W     (LINE_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .mode      (mode),
        .sel       (sel),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sol   (out_sol),
        .out_eol   (out_eol),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Push n pixels (base+k) into the channels selected by mask, one per cycle.
    task automatic push_line(input logic [1:0] mask, input logic [15:0] b0, input logic [15:0] b1, input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = mask;
            in_data  = {b1 + 16'(k), b0 + 16'(k)};
            tick();
        end
        in_valid = 2'b00;
        in_data  = 32'h0;
    endtask

    // Called right after the push that completes the line; checks latency and every beat.
    task automatic run_line(input string tag, input logic [1:0] m, input int s,
                            input logic [15:0] b0, input logic [15:0] b1, input bit stall);
        int          nb;
        int          k;
        int          cyc;
        logic [15:0] p;
        logic [31:0] exp;
        nb = (m == 2'd1) ? 2 * LINE_W : LINE_W;
        check_val({tag, "_lat1"}, 32'(out_valid), 32'd0);
        tick();
        check_val({tag, "_lat2"}, 32'(out_valid), 32'd1);
        k   = 0;
        cyc = 0;
        while (k < nb && cyc < 100) begin
            case (m)
                2'd1: begin
                    p   = (k < LINE_W) ? b0 + 16'(k) : b1 + 16'(k - LINE_W);
                    exp = {16'h0000, p};
                end
                2'd2: begin
                    p   = (s == 1) ? b1 + 16'(k) : b0 + 16'(k);
                    exp = {16'h0000, p};
                end
                default: exp = {b1 + 16'(k), b0 + 16'(k)};
            endcase
            check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
            check_val({tag, "_data"}, out_data, exp);
            check_val({tag, "_sol"}, 32'(out_sol), 32'(k == 0));
            check_val({tag, "_eol"}, 32'(out_eol), 32'(k == nb - 1));
            if (stall) begin
                check_val({tag, "_lvl"}, 32'(dut.g_ch[0].u_fifo.o_level), 32'(LINE_W - k));
            end
            if (k == 3) begin
                mode = 2'd0;
            end
            out_ready = stall ? (cyc % 3 == 0) : 1'b1;
            tick();
            if (out_ready) begin
                k++;
            end
            cyc++;
        end
        out_ready = 1'b1;
        check_val({tag, "_beats"}, 32'(k), 32'(nb));
        check_val({tag, "_idle"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 2'b00;
        in_data   = 32'h0;
        mode      = 2'd0;
        sel       = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_sol", 32'(out_sol), 32'd0);
        check_val("rst_eol", 32'(out_eol), 32'd0);
        check_val("rst_data", out_data, 32'h0);
        check_val("rst_ovf", 32'(overflow), 32'd0);

        // Lockstep, both channels in the same cycles.
        push_line(2'b11, 16'h0000, 16'h1000, LINE_W);
        run_line("ls", 2'd0, 0, 16'h0000, 16'h1000, 1'b0);

        // Skewed: ch0 finishes 20 cycles before ch1.
        push_line(2'b01, 16'h0000, 16'h1000, LINE_W);
        for (int i = 0; i < 12; i++) begin
            tick();
            check_val("skew_wait", 32'(out_valid), 32'd0);
        end
        push_line(2'b10, 16'h0000, 16'h1000, LINE_W);
        run_line("skew", 2'd0, 0, 16'h0000, 16'h1000, 1'b0);

        // Concat.
        mode = 2'd1;
        push_line(2'b11, 16'h0000, 16'h1000, LINE_W);
        run_line("cc", 2'd1, 0, 16'h0000, 16'h1000, 1'b0);

        // Select channel 1; mode is switched to lockstep at beat 3 and must be ignored.
        mode = 2'd2;
        sel  = 1'b1;
        push_line(2'b11, 16'h0000, 16'h1000, LINE_W);
        run_line("sel", 2'd2, 1, 16'h0000, 16'h1000, 1'b0);
        check_val("sel_lvl0", 32'(dut.g_ch[0].u_fifo.o_level), 32'd0);
        check_val("sel_lvl1", 32'(dut.g_ch[1].u_fifo.o_level), 32'd0);

        // Back-pressure, lockstep, ready pattern 1,0,0,1,...
        mode = 2'd0;
        push_line(2'b11, 16'h2000, 16'h3000, LINE_W);
        run_line("bp", 2'd0, 0, 16'h2000, 16'h3000, 1'b1);

        // Flush aborts a line mid-output.
        push_line(2'b11, 16'h5000, 16'h6000, LINE_W);
        tick();
        check_val("abort_start", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush     = 1'b0;
        out_ready = 1'b1;
        check_val("abort_valid", 32'(out_valid), 32'd0);
        check_val("abort_eol", 32'(out_eol), 32'd0);
        check_val("abort_lvl0", 32'(dut.g_ch[0].u_fifo.o_level), 32'd0);
        check_val("abort_lvl1", 32'(dut.g_ch[1].u_fifo.o_level), 32'd0);

        // Overflow on ch0, then flush keeps the flag and reset clears it.
        push_line(2'b01, 16'h4000, 16'h0000, FIFO_DEPTH + 1);
        check_val("ovf_flag", 32'(overflow), 32'd1);
        check_val("ovf_lvl", 32'(dut.g_ch[0].u_fifo.o_level), 32'(FIFO_DEPTH));
        check_val("ovf_valid", 32'(out_valid), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("fl_lvl0", 32'(dut.g_ch[0].u_fifo.o_level), 32'd0);
        check_val("fl_state", 32'(dut.r_state), 32'd0);
        check_val("fl_ovf", 32'(overflow), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("rst_ovf2", 32'(overflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
